hs_pipeline_ctrl: RTL and testbench

Parametrised, clocked, multi-stage 4-phase bundled-data pipeline controller. It generalises the single Rreq generalised-C-element controller into a chain of DEPTH handshake stages, each with its own data register. It reports occupancy and sits between a 4-phase producer (lreq/lack/ldata) and a 4-phase consumer (rreq/rack/rdata) in the controller datapath. Each stage applies the same request rule: set on go & ~ack, hold until ack, drop when acknowledged.

---
 rtl/hs_pkg.sv | 19 +
 rtl/hs_stage.sv | 43 ++++
 rtl/hs_pipeline_ctrl.sv | 59 +++++
 tb/tb_hs_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared sizing helper and stage-rule constants for the 4-phase pipeline controller.
package hs_pkg;

    // Stage-rule documentation constants: one edge each for capture,
    // ack propagate, release and left return-to-zero across a stage boundary.
    localparam int STAGE_FWD_EDGES = 4;

    typedef enum logic [1:0] {
        RULE_HOLD    = 2'd0,
        RULE_CAPTURE = 2'd1,
        RULE_RTZ     = 2'd2,
        RULE_RELEASE = 2'd3
    } hs_rule_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_stage.sv
// One 4-phase bundled-data stage: request/ack/data flops and the capture, RTZ and release rules.
module hs_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             i_ack,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_req,
    output logic             o_ack,
    output logic [WIDTH-1:0] o_dout
);

    logic             r_req;
    logic             r_ack;
    logic [WIDTH-1:0] r_dout;
    logic             w_capture;

    // Capture needs an idle stage and a downstream that has finished its own RTZ.
    assign w_capture = i_req & ~r_ack & ~r_req & ~i_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req  <= 1'b0;
            r_ack  <= 1'b0;
            r_dout <= '0;
        end else if (w_capture) begin
            r_req  <= 1'b1;
            r_ack  <= 1'b1;
            r_dout <= i_din;
        end else begin
            // Release and RTZ are independent and may both fire on one edge.
            if (r_ack & ~i_req) r_ack <= 1'b0;
            if (r_req & i_ack)  r_req <= 1'b0;
        end
    end

    assign o_req  = r_req;
    assign o_ack  = r_ack;
    assign o_dout = r_dout;

endmodule

// File: rtl/hs_pipeline_ctrl.sv
// DEPTH-stage 4-phase bundled-data pipeline with occupancy reporting.
module hs_pipeline_ctrl
    import hs_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lreq,
    output logic             lack,
    input  logic [WIDTH-1:0] ldata,
    output logic             rreq,
    input  logic             rack,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // Chain index k is the boundary on the left of stage k; index DEPTH faces the consumer.
    logic [DEPTH:0]            w_req;
    logic [DEPTH:0]            w_ack;
    logic [DEPTH:0][WIDTH-1:0] w_data;
    logic [CNT_W-1:0]          w_count;

    assign w_req[0]      = lreq;
    assign w_data[0]     = ldata;
    assign w_ack[DEPTH]  = rack;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        hs_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_req  (w_req[k]),
            .i_ack  (w_ack[k+1]),
            .i_din  (w_data[k]),
            .o_req  (w_req[k+1]),
            .o_ack  (w_ack[k]),
            .o_dout (w_data[k+1])
        );
    end

    always_comb begin
        w_count = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_count = w_count + CNT_W'(w_req[k]);
        end
    end

    assign lack  = w_ack[0];
    assign rreq  = w_req[DEPTH];
    assign rdata = w_data[DEPTH];
    assign count = w_count;
    assign full  = (w_count == CNT_W'(DEPTH));
    assign empty = (w_count == '0);

endmodule

// File: tb/tb_hs_pipeline_ctrl.sv
// Directed bench for the 4-stage, 8-bit pipeline controller.
module tb_hs_pipeline_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WAIT_MAX = 60;
    localparam int SETTLE = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             lreq;
    logic             lack;
    logic [WIDTH-1:0] ldata;
    logic             rreq;
    logic             rack;
    logic [WIDTH-1:0] rdata;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;

    hs_pipeline_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .lreq  (lreq),
        .lack  (lack),
        .ldata (ldata),
        .rreq  (rreq),
        .rack  (rack),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (SETTLE) tick();
    endtask

    task automatic wait_lack(input logic v, input string tag);
        int n = 0;
        while (lack !== v && n < WAIT_MAX) begin
            tick();
            n++;
        end
        chk(tag, 32'(lack), 32'(v));
    endtask

    task automatic wait_rreq(input logic v, input string tag);
        int n = 0;
        while (rreq !== v && n < WAIT_MAX) begin
            tick();
            n++;
        end
        chk(tag, 32'(rreq), 32'(v));
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        ldata = d;
        lreq  = 1'b1;
        wait_lack(1'b1, "push_lack_rise");
        lreq  = 1'b0;
        wait_lack(1'b0, "push_lack_fall");
    endtask

    task automatic pop(input logic [WIDTH-1:0] exp, input string tag);
        wait_rreq(1'b1, "pop_rreq_rise");
        chk(tag, 32'(rdata), 32'(exp));
        rack = 1'b1;
        wait_rreq(1'b0, "pop_rreq_fall");
        rack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lack"},  32'(lack),  32'd0);
        chk({tag, "_rreq"},  32'(rreq),  32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'h00);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full),  32'd0);
    endtask

    initial begin
        // Reset with random inputs, observed before the first clock edge.
        rst   = 1'b0;
        lreq  = 1'($urandom);
        rack  = 1'($urandom);
        ldata = 8'($urandom);
        #2;
        chk_reset_outputs("rst0");
        lreq = 1'b0;
        rack = 1'b0;
        #1 rst = 1'b1;
        tick();

        // Single token latency.
        ldata = 8'hA5;
        lreq  = 1'b1;
        tick();
        chk("single_lack_e1", 32'(lack), 32'd1);
        chk("single_rreq_e1", 32'(rreq), 32'd0);
        tick();
        tick();
        chk("single_rreq_e3", 32'(rreq), 32'd0);
        tick();
        chk("single_rreq_e4",  32'(rreq),  32'd1);
        chk("single_rdata_e4", 32'(rdata), 32'hA5);
        tick();
        chk("single_count", 32'(count), 32'd1);
        lreq = 1'b0;
        tick();
        chk("single_lack_rtz", 32'(lack),  32'd0);
        chk("single_empty",    32'(empty), 32'd0);
        rack = 1'b1;
        wait_rreq(1'b0, "single_rreq_fall");
        chk("single_rdata_hold", 32'(rdata), 32'hA5);
        rack = 1'b0;
        settle();
        chk("single_drained", 32'(empty), 32'd1);

        // Fill to capacity, then a fifth request must be refused.
        for (int i = 1; i <= DEPTH; i++) push(8'(i));
        settle();
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full",  32'(full),  32'd1);
        ldata = 8'h55;
        lreq  = 1'b1;
        repeat (20) tick();
        chk("fill_5th_lack", 32'(lack), 32'd0);
        chk("fill_5th_count", 32'(count), 32'd4);
        lreq = 1'b0;
        tick();

        // Drain in order; hold rack high after each release so the count settles.
        for (int i = 0; i < DEPTH; i++) begin
            wait_rreq(1'b1, "drain_rreq_rise");
            chk("drain_rdata", 32'(rdata), 32'(i + 1));
            rack = 1'b1;
            wait_rreq(1'b0, "drain_rreq_fall");
            settle();
            chk("drain_count", 32'(count), 32'(DEPTH - 1 - i));
            rack = 1'b0;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full",  32'(full),  32'd0);

        // Downstream ack stuck high blocks the last stage only.
        rack = 1'b1;
        push(8'h3C);
        settle();
        chk("stuck_count", 32'(count), 32'd1);
        chk("stuck_rreq",  32'(rreq),  32'd0);
        rack = 1'b0;
        tick();
        chk("stuck_rreq_rel",  32'(rreq),  32'd1);
        chk("stuck_rdata_rel", 32'(rdata), 32'h3C);
        pop(8'h3C, "stuck_pop_rdata");
        settle();
        chk("stuck_empty", 32'(empty), 32'd1);

        // Reset mid-flight with two tokens and a half-complete left handshake.
        push(8'h11);
        settle();
        ldata = 8'h22;
        lreq  = 1'b1;
        wait_lack(1'b1, "mid_lack_rise");
        chk("mid_count", 32'(count), 32'd2);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        lreq = 1'b0;
        tick();
        rst = 1'b1;
        ldata = 8'h77;
        lreq  = 1'b1;
        tick();
        chk("post_lack_e1", 32'(lack), 32'd1);
        tick();
        tick();
        chk("post_rreq_e3", 32'(rreq), 32'd0);
        tick();
        chk("post_rreq_e4",  32'(rreq),  32'd1);
        chk("post_rdata_e4", 32'(rdata), 32'h77);
        lreq = 1'b0;
        tick();
        chk("post_lack_rtz", 32'(lack), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
